// File: rtl/hazard_stall_unit_pkg.sv
// Shared definitions for the hazard/stall unit: RV32I opcodes, the hazard FSM
// state encoding and the bundle of pipeline control signals.
package hazard_stall_unit_pkg;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;

  typedef enum logic {
    HZ_RUN      = 1'b0,
    HZ_MEM_WAIT = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic if_id_flush;
    logic id_ex_we;
    logic id_ex_flush;
    logic ex_mem_we;
    logic mem_wb_flush;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_RESET  = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b1,
                                       id_ex_we: 1'b0, id_ex_flush: 1'b1, ex_mem_we: 1'b0,
                                       mem_wb_flush: 1'b1};
  localparam hz_ctrl_t CTRL_FREEZE = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b0,
                                       id_ex_we: 1'b0, id_ex_flush: 1'b0, ex_mem_we: 1'b0,
                                       mem_wb_flush: 1'b1};
  localparam hz_ctrl_t CTRL_BRANCH = '{pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b1,
                                       id_ex_we: 1'b1, id_ex_flush: 1'b1, ex_mem_we: 1'b1,
                                       mem_wb_flush: 1'b0};
  localparam hz_ctrl_t CTRL_LDUSE  = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b0,
                                       id_ex_we: 1'b1, id_ex_flush: 1'b1, ex_mem_we: 1'b1,
                                       mem_wb_flush: 1'b0};
  localparam hz_ctrl_t CTRL_NORMAL = '{pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b0,
                                       id_ex_we: 1'b1, id_ex_flush: 1'b0, ex_mem_we: 1'b1,
                                       mem_wb_flush: 1'b0};

endpackage

// File: rtl/hazard_reg_use_decode.sv
// Source-register decode for an RV32I instruction: which of rs1/rs2 the
// instruction actually reads, and their indices. Shared with the forwarding logic.
module hazard_reg_use_decode
  import hazard_stall_unit_pkg::*;
(
  input  logic [31:0] i_instruction,
  output logic        o_uses_rs1,
  output logic        o_uses_rs2,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2
);

  logic [6:0] w_opcode;
  logic       w_unused_bits;

  assign w_opcode      = i_instruction[6:0];
  assign o_rs1         = i_instruction[19:15];
  assign o_rs2         = i_instruction[24:20];
  assign w_unused_bits = ^{i_instruction[31:25], i_instruction[14:7]};

  // U-type and JAL carry immediate bits where rs1 would sit.
  assign o_uses_rs1 = !((w_opcode == OP_LUI) || (w_opcode == OP_AUIPC) ||
                        (w_opcode == OP_JAL));
  assign o_uses_rs2 = (w_opcode == OP_R) || (w_opcode == OP_S) || (w_opcode == OP_B);

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush/freeze control for the 5-stage RV32I pipeline: load-use bubbles,
// taken-branch flushes and multi-cycle data-memory freezes.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int MEM_TIMEOUT   = 64,
  parameter int COUNTER_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              ID_instruction,
  input  logic [31:0]              EX_instruction,
  input  logic                     EX_reg_write_enable,
  input  logic                     EX_mem_to_reg,
  input  logic                     EX_branch_taken,
  input  logic                     dmem_req,
  input  logic                     dmem_ready,
  output logic                     PC_write_enable,
  output logic                     IF_ID_write_enable,
  output logic                     IF_ID_flush,
  output logic                     ID_EX_write_enable,
  output logic                     ID_EX_flush,
  output logic                     EX_MEM_write_enable,
  output logic                     MEM_WB_flush,
  output logic [COUNTER_WIDTH-1:0] stall_cycles,
  output logic                     mem_timeout
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  hz_state_e                r_state;
  logic [WAIT_W-1:0]        r_wait_cnt;
  logic [COUNTER_WIDTH-1:0] r_stall_cycles;
  logic                     r_mem_timeout;

  logic       w_uses_rs1;
  logic       w_uses_rs2;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic [4:0] w_ex_rd;
  logic       w_load_use;
  logic       w_freeze;
  logic       w_unused_ex;
  hz_ctrl_t   w_ctrl;

  hazard_reg_use_decode u_id_decode (
    .i_instruction (ID_instruction),
    .o_uses_rs1    (w_uses_rs1),
    .o_uses_rs2    (w_uses_rs2),
    .o_rs1         (w_rs1),
    .o_rs2         (w_rs2)
  );

  assign w_ex_rd     = EX_instruction[11:7];
  assign w_unused_ex = ^{EX_instruction[31:12], EX_instruction[6:0]};

  assign w_load_use = EX_reg_write_enable && EX_mem_to_reg && (w_ex_rd != 5'd0) &&
                      ((w_uses_rs1 && (w_rs1 == w_ex_rd)) ||
                       (w_uses_rs2 && (w_rs2 == w_ex_rd)));

  // Once waiting, only dmem_ready matters; the request is assumed held.
  assign w_freeze = (r_state == HZ_MEM_WAIT) ? !dmem_ready : (dmem_req && !dmem_ready);

  always_comb begin
    w_ctrl = CTRL_NORMAL;
    if (!rst_n)               w_ctrl = CTRL_RESET;
    else if (w_freeze)        w_ctrl = CTRL_FREEZE;
    else if (EX_branch_taken) w_ctrl = CTRL_BRANCH;
    else if (w_load_use)      w_ctrl = CTRL_LDUSE;
  end

  assign PC_write_enable     = w_ctrl.pc_we;
  assign IF_ID_write_enable  = w_ctrl.if_id_we;
  assign IF_ID_flush         = w_ctrl.if_id_flush;
  assign ID_EX_write_enable  = w_ctrl.id_ex_we;
  assign ID_EX_flush         = w_ctrl.id_ex_flush;
  assign EX_MEM_write_enable = w_ctrl.ex_mem_we;
  assign MEM_WB_flush        = w_ctrl.mem_wb_flush;
  assign stall_cycles        = r_stall_cycles;
  assign mem_timeout         = r_mem_timeout;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= HZ_RUN;
      r_wait_cnt     <= '0;
      r_stall_cycles <= '0;
      r_mem_timeout  <= 1'b0;
    end else begin
      if (!w_ctrl.pc_we && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + 1'b1;
      case (r_state)
        HZ_RUN: begin
          if (dmem_req && !dmem_ready) begin
            r_state    <= HZ_MEM_WAIT;
            r_wait_cnt <= '0;
          end
        end
        HZ_MEM_WAIT: begin
          if (dmem_ready) begin
            r_state <= HZ_RUN;
          end else begin
            // Counter parks at the limit; the flag is sticky and the freeze persists.
            if (r_wait_cnt != WAIT_MAX) r_wait_cnt <= r_wait_cnt + 1'b1;
            if (r_wait_cnt == WAIT_LAST) r_mem_timeout <= 1'b1;
          end
        end
        default: r_state <= HZ_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_hazard_stall_unit;

  localparam int TO = 4;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;

  localparam logic [6:0] C_RESET  = 7'b0010101;
  localparam logic [6:0] C_FREEZE = 7'b0000001;
  localparam logic [6:0] C_BRANCH = 7'b1111110;
  localparam logic [6:0] C_LDUSE  = 7'b0001110;
  localparam logic [6:0] C_NORMAL = 7'b1101010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [31:0]   id_i, ex_i;
  logic          ex_we, ex_m2r, ex_br, req, rdy;
  logic          pc_we, ifid_we, ifid_fl, idex_we, idex_fl, exmem_we, memwb_fl;
  logic [CW-1:0] stall;
  logic          tmo;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit m_wait, m_to;
  int m_cnt, m_stall;

  hazard_stall_unit #(.MEM_TIMEOUT(TO), .COUNTER_WIDTH(CW)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .ID_instruction      (id_i),
    .EX_instruction      (ex_i),
    .EX_reg_write_enable (ex_we),
    .EX_mem_to_reg       (ex_m2r),
    .EX_branch_taken     (ex_br),
    .dmem_req            (req),
    .dmem_ready          (rdy),
    .PC_write_enable     (pc_we),
    .IF_ID_write_enable  (ifid_we),
    .IF_ID_flush         (ifid_fl),
    .ID_EX_write_enable  (idex_we),
    .ID_EX_flush         (idex_fl),
    .EX_MEM_write_enable (exmem_we),
    .MEM_WB_flush        (memwb_fl),
    .stall_cycles        (stall),
    .mem_timeout         (tmo)
  );

  function automatic logic [31:0] enc_r(int rd, int rs1, int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(int rd, int rs1, int imm, logic [6:0] op);
    return {12'(imm), 5'(rs1), 3'b010, 5'(rd), op};
  endfunction

  function automatic logic [6:0] dut_ctrl();
    return {pc_we, ifid_we, ifid_fl, idex_we, idex_fl, exmem_we, memwb_fl};
  endfunction

  function automatic logic [6:0] exp_ctrl();
    logic [6:0] op;
    logic [4:0] rd;
    bit         u1, u2, lu, frz;
    if (!rst_n) return C_RESET;
    frz = m_wait ? !rdy : (req && !rdy);
    if (frz) return C_FREEZE;
    if (ex_br) return C_BRANCH;
    op = id_i[6:0];
    rd = ex_i[11:7];
    u1 = !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
    u2 = (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011);
    lu = ex_we && ex_m2r && (rd != 0) &&
         ((u1 && id_i[19:15] == rd) || (u2 && id_i[24:20] == rd));
    return lu ? C_LDUSE : C_NORMAL;
  endfunction

  task automatic tick();
    logic [6:0] c;
    c = exp_ctrl();
    @(posedge clk);
    if (!rst_n) begin
      m_wait = 0; m_cnt = 0; m_stall = 0; m_to = 0;
    end else begin
      if (!c[6] && m_stall < SAT) m_stall++;
      if (m_wait) begin
        if (rdy) m_wait = 0;
        else begin
          if (m_cnt < TO) m_cnt++;
          if (m_cnt >= TO) m_to = 1;
        end
      end else if (req && !rdy) begin
        m_wait = 1; m_cnt = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic set_idle();
    id_i = 32'h0000_0013; ex_i = 32'h0000_0013;
    ex_we = 0; ex_m2r = 0; ex_br = 0; req = 0; rdy = 0;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 0; req = 1; rdy = 0; ex_br = 1;
    #1;
    n_checks++;
    if (dut_ctrl() !== C_RESET) begin
      n_fail++; $display("FAIL reset_ctrl got %b want %b", dut_ctrl(), C_RESET);
    end
    tick(); tick();
    n_checks++;
    if (stall !== '0 || tmo !== 1'b0) begin
      n_fail++; $display("FAIL reset_regs got stall=%0d tmo=%b want 0 0", stall, tmo);
    end
    rst_n = 1; set_idle();
  endtask

  task automatic test_load_use();
    do_reset();
    ex_i = enc_i(5, 1, 0, 7'b0000011); ex_we = 1; ex_m2r = 1;
    id_i = enc_r(6, 5, 1);
    #1;
    n_checks++;
    if (dut_ctrl() !== C_LDUSE) begin
      n_fail++; $display("FAIL load_use_stall got %b want %b", dut_ctrl(), C_LDUSE);
    end
    tick();
    ex_i = 32'h0; ex_we = 0; ex_m2r = 0;
    #1;
    n_checks++;
    if (dut_ctrl() !== C_NORMAL || stall !== CW'(1)) begin
      n_fail++; $display("FAIL load_use_after got %b stall=%0d want %b stall=1",
                         dut_ctrl(), stall, C_NORMAL);
    end
    tick();
  endtask

  task automatic test_no_false_stall();
    do_reset();
    ex_we = 1; ex_m2r = 1;
    ex_i = enc_i(5, 1, 0, 7'b0000011);
    id_i = {12'h000, 5'd5, 3'b000, 5'd5, 7'b0110111};
    #1;
    n_checks++;
    if (dut_ctrl() !== C_NORMAL) begin
      n_fail++; $display("FAIL nostall_lui got %b want %b", dut_ctrl(), C_NORMAL);
    end
    tick();
    ex_i = enc_i(0, 1, 0, 7'b0000011);
    id_i = enc_r(1, 0, 0);
    #1;
    n_checks++;
    if (dut_ctrl() !== C_NORMAL) begin
      n_fail++; $display("FAIL nostall_x0 got %b want %b", dut_ctrl(), C_NORMAL);
    end
    tick();
    ex_i = enc_i(5, 1, 0, 7'b0000011);
    id_i = enc_i(6, 7, 5, 7'b0010011);
    #1;
    n_checks++;
    if (dut_ctrl() !== C_NORMAL || stall !== '0) begin
      n_fail++; $display("FAIL nostall_rs2_unused got %b stall=%0d want %b stall=0",
                         dut_ctrl(), stall, C_NORMAL);
    end
    tick();
  endtask

  task automatic test_branch_precedence();
    do_reset();
    ex_i = enc_i(5, 1, 0, 7'b0000011); ex_we = 1; ex_m2r = 1;
    id_i = enc_r(6, 5, 1); ex_br = 1;
    #1;
    n_checks++;
    if (dut_ctrl() !== C_BRANCH) begin
      n_fail++; $display("FAIL branch_over_load_use got %b want %b", dut_ctrl(), C_BRANCH);
    end
    tick();
    set_idle();
  endtask

  task automatic test_mem_wait();
    do_reset();
    req = 1; rdy = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (dut_ctrl() !== C_FREEZE) begin
        n_fail++; $display("FAIL mem_wait_freeze[%0d] got %b want %b", i, dut_ctrl(), C_FREEZE);
      end
      tick();
    end
    rdy = 1;
    #1;
    n_checks++;
    if (dut_ctrl() !== C_NORMAL) begin
      n_fail++; $display("FAIL mem_wait_release got %b want %b", dut_ctrl(), C_NORMAL);
    end
    tick();
    req = 0; rdy = 0;
    #1;
    n_checks++;
    if (dut_ctrl() !== C_NORMAL || stall !== CW'(3)) begin
      n_fail++; $display("FAIL mem_wait_back_to_run got %b stall=%0d want %b stall=3",
                         dut_ctrl(), stall, C_NORMAL);
    end
    tick();
    req = 1; rdy = 1;
    #1;
    n_checks++;
    if (dut_ctrl() !== C_NORMAL) begin
      n_fail++; $display("FAIL zero_wait got %b want %b", dut_ctrl(), C_NORMAL);
    end
    tick();
    req = 0; rdy = 0;
    #1;
    n_checks++;
    if (dut_ctrl() !== C_NORMAL) begin
      n_fail++; $display("FAIL zero_wait_stays_run got %b want %b", dut_ctrl(), C_NORMAL);
    end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    req = 1; rdy = 0;
    tick();
    for (int i = 1; i <= TO; i++) begin
      tick();
      n_checks++;
      if (tmo !== (i == TO)) begin
        n_fail++; $display("FAIL timeout_wait[%0d] got %b want %b", i, tmo, (i == TO));
      end
    end
    rdy = 1;
    tick();
    req = 0; rdy = 0;
    tick();
    n_checks++;
    if (tmo !== 1'b1 || dut_ctrl() !== C_NORMAL) begin
      n_fail++; $display("FAIL timeout_sticky got tmo=%b ctrl=%b want 1 %b", tmo, dut_ctrl(), C_NORMAL);
    end
    do_reset();
    n_checks++;
    if (tmo !== 1'b0) begin
      n_fail++; $display("FAIL timeout_cleared got %b want 0", tmo);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    req = 1; rdy = 0;
    tick(); tick();
    rst_n = 0; req = 0;
    #1;
    n_checks++;
    if (dut_ctrl() !== C_RESET) begin
      n_fail++; $display("FAIL reset_mid_wait_ctrl got %b want %b", dut_ctrl(), C_RESET);
    end
    tick();
    rst_n = 1;
    #1;
    n_checks++;
    if (dut_ctrl() !== C_NORMAL || stall !== '0 || tmo !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_wait_after got %b stall=%0d tmo=%b want %b 0 0",
                         dut_ctrl(), stall, tmo, C_NORMAL);
    end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    req = 1; rdy = 0;
    for (int i = 0; i < SAT + 5; i++) tick();
    n_checks++;
    if (stall !== CW'(SAT)) begin
      n_fail++; $display("FAIL stall_saturate got %0d want %0d", stall, SAT);
    end
    tick();
    n_checks++;
    if (stall !== CW'(SAT)) begin
      n_fail++; $display("FAIL stall_hold got %0d want %0d", stall, SAT);
    end
    set_idle();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [9] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0110011,
                            7'b0100011, 7'b1100011, 7'b0010011, 7'b0000011};
    logic [31:0] w;
    w = $urandom;
    w[6:0]   = ops[$urandom_range(0, 8)];
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    return w;
  endfunction

  task automatic test_random();
    logic [6:0] e;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst_n  = ($urandom_range(0, 39) != 0);
      id_i   = rand_instr();
      ex_i   = rand_instr();
      ex_we  = ($urandom_range(0, 3) != 0);
      ex_m2r = ($urandom_range(0, 1) != 0);
      ex_br  = ($urandom_range(0, 5) == 0);
      req    = ($urandom_range(0, 2) == 0);
      rdy    = ($urandom_range(0, 2) != 0);
      #1;
      e = exp_ctrl();
      n_checks++;
      if (dut_ctrl() !== e || stall !== CW'(m_stall) || tmo !== m_to) begin
        n_fail++;
        $display("FAIL random[%0d] got ctrl=%b stall=%0d tmo=%b want ctrl=%b stall=%0d tmo=%b",
                 i, dut_ctrl(), stall, tmo, e, m_stall, m_to);
      end
      tick();
    end
    rst_n = 1; set_idle();
  endtask

  initial begin
    set_idle();
    rst_n = 0;
    m_wait = 0; m_to = 0; m_cnt = 0; m_stall = 0;
    @(negedge clk);
    test_reset();
    test_load_use();
    test_no_false_stall();
    test_branch_precedence();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
